// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: register
// address/data widths and the arbiter state encoding.
package wb_port_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Arbiter state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 2'd0;  // buffer empty
    localparam arb_state_t ST_HOLD  = 2'd1;  // buffer full, waiting for a free slot
    localparam arb_state_t ST_FORCE = 2'd2;  // buffer full, port taken from the pipeline

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline writeback, multiply/divide offer and register-file
// write signals shared by the write-port arbiter and its environment.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic      wb_valid_w;
    reg_addr_t rd_w;
    reg_data_t result_w;
    logic      md_valid;
    reg_addr_t md_rd;
    reg_data_t md_result;
    logic      md_ready;
    logic      stall_w;
    logic      md_pending;
    reg_addr_t md_pending_rd;
    logic      rf_we;
    reg_addr_t rf_waddr;
    reg_data_t rf_wdata;

    // Arbiter side.
    modport slave (
        input  wb_valid_w, rd_w, result_w, md_valid, md_rd, md_result,
        output md_ready, stall_w, md_pending, md_pending_rd,
               rf_we, rf_waddr, rf_wdata
    );

    // Pipeline / multiply-divide / register-file side.
    modport master (
        output wb_valid_w, rd_w, result_w, md_valid, md_rd, md_result,
        input  md_ready, stall_w, md_pending, md_pending_rd,
               rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_port_arbiter_skid.sv
// One-entry holding buffer for a multiply/divide result (wb_skid_buf):
// load captures rd/data, clear empties it, otherwise it holds.
module wb_skid_buf
    import wb_port_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      clear_i,
    input  reg_addr_t rd_i,
    input  reg_data_t data_i,
    output reg_addr_t rd_o,
    output reg_data_t data_o
);

    reg_addr_t rd_q;
    reg_data_t data_q;

    // Capture on load, empty on clear, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            data_q <= '0;
        end else if (load_i) begin
            rd_q   <= rd_i;
            data_q <= data_i;
        end else if (clear_i) begin
            rd_q   <= '0;
            data_q <= '0;
        end
    end

    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback stage and
// a multiply/divide unit. Pipeline writes win while a buffered md result
// waits; after STARVE_LIMIT lost cycles the md result forces the port and
// stalls writeback for one cycle.
// Optional macro WB_ARB_PERF_EN adds perf_wait_cnt (cycles spent buffered).
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]       perf_wait_cnt
`endif
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   CNT_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   LIMIT_V = (CNT_W + 1)'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W:0]   wait_inc;

    logic      buf_load, buf_clear;
    reg_addr_t buf_rd;
    reg_data_t buf_data;

    logic      slot_taken;
    logic      md_ready_c, stall_c, we_c;
    reg_addr_t waddr_c;
    reg_data_t wdata_c;
    logic      pending;

    wb_skid_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .rd_i    (bus.md_rd),
        .data_i  (bus.md_result),
        .rd_o    (buf_rd),
        .data_o  (buf_data)
    );

    // A pipeline write to x0 never claims the port.
    assign slot_taken = bus.wb_valid_w && (bus.rd_w != '0);
    assign wait_inc   = {1'b0, wait_q} + CNT_ONE;

    // Next state, wait counter and write-port mux.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        md_ready_c = 1'b0;
        stall_c    = 1'b0;
        we_c       = 1'b0;
        waddr_c    = bus.rd_w;
        wdata_c    = bus.result_w;
        case (state_q)
            ST_IDLE: begin
                md_ready_c = 1'b1;
                we_c       = slot_taken;
                wait_d     = '0;
                if (bus.md_valid) begin
                    buf_load = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (slot_taken) begin
                    we_c   = 1'b1;
                    wait_d = (wait_q == CNT_MAX) ? wait_q : wait_inc[CNT_W-1:0];
                    if (wait_inc >= LIMIT_V) begin
                        state_d = ST_FORCE;
                    end
                end else begin
                    // Free slot: retire the buffered result (x0 writes nothing).
                    we_c      = (buf_rd != '0);
                    waddr_c   = buf_rd;
                    wdata_c   = buf_data;
                    buf_clear = 1'b1;
                    wait_d    = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_FORCE: begin
                stall_c   = 1'b1;
                we_c      = (buf_rd != '0);
                waddr_c   = buf_rd;
                wdata_c   = buf_data;
                buf_clear = 1'b1;
                wait_d    = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                buf_clear = 1'b1;
                wait_d    = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign pending = (state_q == ST_HOLD) || (state_q == ST_FORCE);

    assign bus.md_ready      = md_ready_c;
    assign bus.stall_w       = stall_c;
    assign bus.md_pending    = pending;
    assign bus.md_pending_rd = pending ? buf_rd : '0;
    // Write enable is gated directly by reset so nothing reaches the file.
    assign bus.rf_we         = we_c && rst_n;
    assign bus.rf_waddr      = waddr_c;
    assign bus.rf_wdata      = wdata_c;

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_q;

    // Count every cycle a result sits buffered; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (pending) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_wait_cnt = perf_q;
`endif

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: maximum cycles a buffered multiply/divide result waits before it forces the write port.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_valid_w  input  1  pipeline writeback stage holds an instruction that writes rd
- rd_w  input  5  pipeline destination register
- result_w  input  32  pipeline writeback data (output of writeback result select)
- md_valid  input  1  multiply/divide unit offers a result
- md_rd  input  5  multiply/divide destination register
- md_result  input  32  multiply/divide result data
- md_ready  output  1  arbiter accepts the offered multiply/divide result
- stall_w  output  1  pipeline shall hold its writeback stage this cycle
- md_pending  output  1  a multiply/divide result is buffered, not yet written
- md_pending_rd  output  5  destination of the buffered result, for hazard detection
- rf_we  output  1  register file write enable
- rf_waddr  output  5  register file write address
- rf_wdata  output  32  register file write data

Function
REQ-003 The block SHALL implement states IDLE (buffer empty), HOLD (buffer full, waiting for a free slot), FORCE (buffer full, port taken from the pipeline).
REQ-004 md_ready SHALL be 1 exactly in IDLE; md_valid&&md_ready loads md_rd/md_result into a one-entry buffer and moves to HOLD next cycle.
REQ-005 A pipeline write with rd_w==0 SHALL NOT occupy the port: rf_we=0 and the slot counts as free.
REQ-006 In IDLE and HOLD, a pipeline write with wb_valid_w=1 and rd_w!=0 SHALL have priority: rf_we=1, rf_waddr=rd_w, rf_wdata=result_w, same cycle (combinational path, zero latency).
REQ-007 In HOLD with a free slot, the buffered result SHALL be written (rf_we=1 if buffered rd!=0, else 0) and the state SHALL return to IDLE; the minimum accept-to-write latency is 1 cycle.
REQ-008 In HOLD with the slot taken, a wait counter SHALL increment; when it reaches STARVE_LIMIT the next state SHALL be FORCE.
REQ-009 In FORCE, stall_w SHALL be 1, the buffered result SHALL be written regardless of wb_valid_w, the pipeline write SHALL be suppressed, and the state SHALL return to IDLE after exactly one cycle.
REQ-010 md_pending SHALL be 1 in HOLD and FORCE; md_pending_rd SHALL equal the buffered rd then, else 0.
REQ-011 The wait counter SHALL clear on every entry to IDLE and SHALL saturate, never wrap.
REQ-012 A new result SHALL NOT be accepted in the cycle the buffer drains; md_ready rises the following cycle.
REQ-013 stall_w SHALL be 0 in IDLE and HOLD.

Reset
REQ-014 On rst_n low, asynchronously: state IDLE, buffer and wait counter cleared, md_ready=1 after release, stall_w=0, md_pending=0, md_pending_rd=0; rf_we SHALL be 0 while rst_n is low.
REQ-015 Reset in HOLD or FORCE SHALL discard the buffered result without writing it.

Configuration
REQ-016 With macro WB_ARB_PERF_EN defined, the block SHALL add output perf_wait_cnt (32 bits) counting every cycle spent in HOLD or FORCE, reset to 0 and wrapping at 2^32; without it, the port and counter SHALL NOT exist.

Structure
REQ-017 State encoding typedef, register address width (5) and data width (32) SHALL reside in the shared core package.
REQ-018 The one-entry buffer SHALL be a sub-module wb_skid_buf (load, clear, data/rd hold); the FSM and muxing stay in wb_port_arbiter.

Verification
REQ-019 Idle pipeline: md_valid=1, md_rd=5, md_result=0xDEADBEEF at cycle 0 -> md_ready=1 cycle 0; cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; md_ready=1 at cycle 2.
REQ-020 Pipeline busy: wb_valid_w=1, rd_w=3 every cycle, md result rd=7 accepted -> rd=3 written 4 cycles, then FORCE: stall_w=1, rf_waddr=7 written, rd=3 write suppressed that cycle.
REQ-021 Pipeline writes rd_w=0 while md result rd=9 buffered -> rf_waddr=9 written that cycle, no stall.
REQ-022 md result rd=0 accepted, pipeline idle -> buffer retires next cycle with rf_we=0, md_pending falls.
REQ-023 rst_n asserted in HOLD with rd=12 buffered -> md_pending=0 immediately, rd=12 never written.
REQ-024 With WB_ARB_PERF_EN, scenario REQ-020 -> perf_wait_cnt=5 afterwards.
